// File: rtl/lfsr_bist_sequencer.sv
// Sequences an external XNOR LFSR for BIST: capture config, seed-load, stream words, fold a rotating-XOR signature.
// Start->LOAD 1 cycle, first word 2 cycles after start; the LFSR advances only on a valid/ready handshake.
module lfsr_bist_sequencer #(
    parameter int WIDTH        = 8,
    parameter int TAP_COUNT    = 4,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_WRAP = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [WIDTH-1:0]           i_cfg_seed,
    input  logic [TAP_COUNT*WIDTH-1:0] i_cfg_taps,
    input  logic [CNT_W-1:0]           i_cfg_count,
    output logic                       o_lfsr_enable,
    output logic                       o_lfsr_seed_load,
    output logic [WIDTH-1:0]           o_lfsr_seed,
    output logic [TAP_COUNT*WIDTH-1:0] o_lfsr_taps,
    input  logic [WIDTH-1:0]           i_lfsr_value,
    input  logic                       i_lfsr_wrap,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_wrapped,
    output logic                       o_aborted,
    output logic [CNT_W-1:0]           o_words,
    output logic [WIDTH-1:0]           o_signature
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [WIDTH-1:0]           seed_q, seed_d;
    logic [TAP_COUNT*WIDTH-1:0] taps_q, taps_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [CNT_W-1:0]           words_q, words_d;
    logic [WIDTH-1:0]           sig_q, sig_d;
    logic                       wrapped_q, wrapped_d;
    logic                       aborted_q, aborted_d;

    logic             wrap_hit;
    logic             wrap_stop;
    logic             hs;
    logic [CNT_W-1:0] words_inc;

    always_comb begin
        state_d          = state_q;
        seed_d           = seed_q;
        taps_d           = taps_q;
        count_d          = count_q;
        words_d          = words_q;
        sig_d            = sig_q;
        wrapped_d        = wrapped_q;
        aborted_d        = aborted_q;
        o_lfsr_enable    = 1'b0;
        o_lfsr_seed_load = 1'b0;
        o_valid          = 1'b0;
        o_busy           = 1'b0;
        o_done           = 1'b0;
        hs               = 1'b0;
        words_inc        = words_q + 1'b1;
        // The first word is always the seed itself, so it never counts as a wrap.
        wrap_hit         = (state_q == S_RUN) && i_lfsr_wrap && (words_q != '0);
        wrap_stop        = wrap_hit && STOP_ON_WRAP;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    seed_d    = i_cfg_seed;
                    taps_d    = i_cfg_taps;
                    count_d   = i_cfg_count;
                    words_d   = '0;
                    sig_d     = '0;
                    wrapped_d = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                o_busy           = 1'b1;
                o_lfsr_enable    = 1'b1;
                o_lfsr_seed_load = 1'b1;
                if (i_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (count_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                o_busy        = 1'b1;
                o_valid       = !wrap_stop;
                hs            = o_valid && i_ready;
                o_lfsr_enable = hs;
                if (hs) begin
                    words_d = words_inc;
                    sig_d   = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ i_lfsr_value;
                end
                if (wrap_hit) begin
                    wrapped_d = 1'b1;
                end
                // Abort outranks both wrap and count termination.
                if (i_abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (wrap_stop) begin
                    state_d = S_DONE;
                end else if (hs && (words_inc == count_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            taps_q    <= '0;
            count_q   <= '0;
            words_q   <= '0;
            sig_q     <= '0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            taps_q    <= taps_d;
            count_q   <= count_d;
            words_q   <= words_d;
            sig_q     <= sig_d;
            wrapped_q <= wrapped_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_lfsr_seed = seed_q;
    assign o_lfsr_taps = taps_q;
    assign o_data      = o_valid ? i_lfsr_value : '0;
    assign o_wrapped   = wrapped_q;
    assign o_aborted   = aborted_q;
    assign o_words     = words_q;
    assign o_signature = sig_q;

endmodule

// File: tb/tb_lfsr_bist_sequencer.sv
// Bench for lfsr_bist_sequencer: golden XNOR LFSR datapath, word/signature scoreboard, directed scenarios.
module tb_lfsr_bist_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden LFSR step: shift left, XNOR of 1-based tap positions into bit 0; tap 0 is unused.
    function automatic logic [7:0] step8(input logic [7:0] v, input logic [31:0] taps);
        logic fb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t = int'(taps[i*8 +: 8]);
            if (t != 0 && t <= 8) fb ^= v[t-1];
        end
        return {v[6:0], fb};
    endfunction

    function automatic logic [2:0] step3(input logic [2:0] v, input logic [11:0] taps);
        logic fb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int t = int'(taps[i*3 +: 3]);
            if (t != 0 && t <= 3) fb ^= v[t-1];
        end
        return {v[1:0], fb};
    endfunction

    // ---------------- 8-bit DUT ----------------
    logic        start8, abort8, ready8;
    logic [7:0]  cfg_seed8;
    logic [31:0] cfg_taps8;
    logic [15:0] cfg_count8;
    logic        en8, sload8, valid8, busy8, done8, wrapped8, aborted8;
    logic [7:0]  seed_out8, data8, sig8, val8;
    logic [31:0] taps_out8;
    logic [15:0] words8;
    logic        wrap8;

    lfsr_bist_sequencer #(.WIDTH(8), .TAP_COUNT(4), .CNT_W(16), .STOP_ON_WRAP(1'b1)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_abort(abort8),
        .i_cfg_seed(cfg_seed8), .i_cfg_taps(cfg_taps8), .i_cfg_count(cfg_count8),
        .o_lfsr_enable(en8), .o_lfsr_seed_load(sload8), .o_lfsr_seed(seed_out8),
        .o_lfsr_taps(taps_out8), .i_lfsr_value(val8), .i_lfsr_wrap(wrap8),
        .o_data(data8), .o_valid(valid8), .i_ready(ready8), .o_busy(busy8),
        .o_done(done8), .o_wrapped(wrapped8), .o_aborted(aborted8),
        .o_words(words8), .o_signature(sig8)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) val8 <= '0;
        else if (en8) val8 <= sload8 ? seed_out8 : step8(val8, taps_out8);
    end
    assign wrap8 = (val8 == seed_out8);

    // ---------------- 3-bit DUT (wrap scenario) ----------------
    logic        start3, abort3, ready3;
    logic [2:0]  cfg_seed3;
    logic [11:0] cfg_taps3;
    logic [15:0] cfg_count3;
    logic        en3, sload3, valid3, busy3, done3, wrapped3, aborted3;
    logic [2:0]  seed_out3, data3, sig3, val3;
    logic [11:0] taps_out3;
    logic [15:0] words3;
    logic        wrap3;

    lfsr_bist_sequencer #(.WIDTH(3), .TAP_COUNT(4), .CNT_W(16), .STOP_ON_WRAP(1'b1)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_abort(abort3),
        .i_cfg_seed(cfg_seed3), .i_cfg_taps(cfg_taps3), .i_cfg_count(cfg_count3),
        .o_lfsr_enable(en3), .o_lfsr_seed_load(sload3), .o_lfsr_seed(seed_out3),
        .o_lfsr_taps(taps_out3), .i_lfsr_value(val3), .i_lfsr_wrap(wrap3),
        .o_data(data3), .o_valid(valid3), .i_ready(ready3), .o_busy(busy3),
        .o_done(done3), .o_wrapped(wrapped3), .o_aborted(aborted3),
        .o_words(words3), .o_signature(sig3)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) val3 <= '0;
        else if (en3) val3 <= sload3 ? seed_out3 : step3(val3, taps_out3);
    end
    assign wrap3 = (val3 == seed_out3);

    // ---------------- Scoreboard for the 8-bit DUT ----------------
    // Expected stream is seed, step(seed), ...; each accepted word is folded into the signature.
    logic [7:0]  mdl_val  = '0;
    logic [7:0]  mdl_sig  = '0;
    logic [15:0] mdl_words = '0;
    int start_req  = 0;
    int start_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_val   = '0;
            mdl_sig   = '0;
            mdl_words = '0;
        end else begin
            if (valid8) begin
                check("data8", data8, mdl_val);
                check("enable8", en8, ready8);
            end
            check("words8", words8, mdl_words);
            check("sig8", sig8, mdl_sig);
            if (valid8 && ready8) begin
                mdl_sig   = {mdl_sig[6:0], mdl_sig[7]} ^ mdl_val;
                mdl_val   = step8(mdl_val, cfg_taps8);
                mdl_words = mdl_words + 16'd1;
            end
            if (start_req != start_seen) begin
                start_seen = start_req;
                mdl_val    = cfg_seed8;
                mdl_sig    = '0;
                mdl_words  = '0;
            end
        end
    end

    task automatic start_run8(input logic [7:0] seed, input logic [15:0] count);
        cfg_seed8  = seed;
        cfg_count8 = count;
        start8     = 1'b1;
        start_req++;
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input string name, input int max_cyc);
        logic seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (done8) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1'b1);
    endtask

    logic [2:0] seq3 [7] = '{3'd0, 3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4};

    initial begin
        logic [7:0] hold;
        int         k;
        logic       seen;

        rst_n      = 1'b0;
        start8     = 1'b0;
        abort8     = 1'b0;
        ready8     = 1'b0;
        cfg_seed8  = '0;
        cfg_taps8  = {8'd1, 8'd5, 8'd6, 8'd8};
        cfg_count8 = '0;
        start3     = 1'b0;
        abort3     = 1'b0;
        ready3     = 1'b0;
        cfg_seed3  = '0;
        cfg_taps3  = {3'd0, 3'd0, 3'd2, 3'd3};
        cfg_count3 = '0;

        repeat (3) tick();
        check("rst_valid", valid8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_enable", en8, 1'b0);
        check("rst_seed", seed_out8, 8'h00);
        check("rst_taps", taps_out8, 32'h0);
        check("rst_words", words8, 16'h0);
        check("rst_sig", sig8, 8'h00);
        rst_n = 1'b1;
        repeat (2) tick();

        // Zero count: LOAD then DONE, no words.
        start_run8(8'h37, 16'd0);
        check("zc_load_busy", busy8, 1'b1);
        check("zc_load_sload", sload8, 1'b1);
        check("zc_load_enable", en8, 1'b1);
        check("zc_load_valid", valid8, 1'b0);
        check("zc_load_seed", seed_out8, 8'h37);
        check("zc_load_taps", taps_out8, 32'h01050608);
        tick();
        check("zc_done", done8, 1'b1);
        check("zc_done_busy", busy8, 1'b0);
        check("zc_done_valid", valid8, 1'b0);
        check("zc_words", words8, 16'd0);
        check("zc_sig", sig8, 8'h00);
        tick();
        check("zc_done_pulse", done8, 1'b0);

        // Two words at full throughput: 0x01, 0x02 -> signature 0x00.
        ready8 = 1'b1;
        tick();
        start_run8(8'h01, 16'd2);
        tick();
        check("tw_valid0", valid8, 1'b1);
        check("tw_data0", data8, 8'h01);
        tick();
        check("tw_valid1", valid8, 1'b1);
        check("tw_data1", data8, 8'h02);
        tick();
        check("tw_done", done8, 1'b1);
        check("tw_valid_off", valid8, 1'b0);
        check("tw_words", words8, 16'd2);
        check("tw_sig", sig8, 8'h00);
        tick();

        // Backpressure: five-cycle stall after the first handshake.
        start_run8(8'h5A, 16'd3);
        tick();
        check("bp_first", data8, 8'h5A);
        tick();
        ready8 = 1'b0;
        hold   = data8;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_stall_valid", valid8, 1'b1);
            check("bp_stall_data", data8, hold);
            check("bp_stall_enable", en8, 1'b0);
            tick();
        end
        ready8 = 1'b1;
        wait_done8("bp_done_seen", 20);
        check("bp_words", words8, 16'd3);
        check("bp_wrapped", wrapped8, 1'b0);
        tick();

        // Abort together with the 4th handshake.
        start_run8(8'h33, 16'd100);
        repeat (3) tick();
        tick();
        abort8 = 1'b1;
        tick();
        abort8 = 1'b0;
        check("ab_done", done8, 1'b1);
        check("ab_words", words8, 16'd4);
        check("ab_aborted", aborted8, 1'b1);
        check("ab_valid", valid8, 1'b0);
        tick();

        // Start during RUN is ignored; the sticky abort flag clears on the new run.
        start_run8(8'h81, 16'd6);
        check("sb_aborted_clr", aborted8, 1'b0);
        tick();
        tick();
        cfg_seed8  = 8'h44;
        cfg_count8 = 16'd2;
        start8     = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8("sb_done_seen", 20);
        check("sb_words", words8, 16'd6);
        check("sb_seed_kept", seed_out8, 8'h81);
        check("sb_aborted", aborted8, 1'b0);
        tick();

        // Asynchronous reset mid-run.
        start_run8(8'h11, 16'd50);
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_valid", valid8, 1'b0);
        check("ar_busy", busy8, 1'b0);
        check("ar_enable", en8, 1'b0);
        check("ar_sload", sload8, 1'b0);
        check("ar_data", data8, 8'h00);
        check("ar_words", words8, 16'h0);
        check("ar_sig", sig8, 8'h00);
        check("ar_seed", seed_out8, 8'h00);
        check("ar_taps", taps_out8, 32'h0);
        check("ar_done", done8, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_run8(8'h01, 16'd2);
        wait_done8("ar_rerun_done", 10);
        check("ar_rerun_words", words8, 16'd2);
        check("ar_rerun_sig", sig8, 8'h00);
        tick();

        // Wrap stop on the 3-bit LFSR: 000,001,011,110,101,010,100 then back to seed.
        ready3     = 1'b1;
        cfg_seed3  = 3'b000;
        cfg_count3 = 16'd10;
        start3     = 1'b1;
        tick();
        start3 = 1'b0;
        k      = 0;
        seen   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done3) begin
                seen = 1'b1;
                break;
            end
            if (valid3) begin
                if (k < 7) check("wr_data", data3, seq3[k]);
                k++;
            end
        end
        check("wr_done_seen", seen, 1'b1);
        check("wr_word_cycles", k, 7);
        check("wr_words", words3, 16'd7);
        check("wr_wrapped", wrapped3, 1'b1);
        check("wr_sig", sig3, 3'h2);
        check("wr_aborted", aborted3, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_bist_sequencer.md
Name: lfsr_bist_sequencer

Overview:
Controller that sequences one external XNOR LFSR datapath for built-in self-test pattern generation. It loads a seed and programs the taps, then advances the LFSR once per accepted word. It streams each LFSR value to a consumer over a valid/ready interface and folds every transferred word into a rotating-XOR signature. A run ends after a programmed word count, on wrap-around to the seed (optional), or on abort.

Parameters:
WIDTH, 8, LFSR and data width in bits (3..168)
TAP_COUNT, 4, number of tap-position fields driven to the LFSR
CNT_W, 16, width of the word-count configuration and counter
STOP_ON_WRAP, 1, 1 = end the run when the LFSR returns to the seed; 0 = flag the wrap only

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_start  in  1  start pulse; sampled only in IDLE
i_abort  in  1  terminate the run; honoured in LOAD and RUN
i_cfg_seed  in  WIDTH  seed value; captured at start
i_cfg_taps  in  TAP_COUNT*WIDTH  packed tap positions; captured at start
i_cfg_count  in  CNT_W  number of words to emit; captured at start
o_lfsr_enable  out  1  LFSR advance/load enable
o_lfsr_seed_load  out  1  LFSR seed-load strobe
o_lfsr_seed  out  WIDTH  captured seed, driven to the LFSR
o_lfsr_taps  out  TAP_COUNT*WIDTH  captured taps, driven to the LFSR
i_lfsr_value  in  WIDTH  current LFSR state
i_lfsr_wrap  in  1  LFSR state equals the seed
o_data  out  WIDTH  pattern word (= i_lfsr_value)
o_valid  out  1  pattern word valid
i_ready  in  1  consumer accepts the word
o_busy  out  1  high in LOAD and RUN
o_done  out  1  one-cycle pulse in DONE
o_wrapped  out  1  sticky: wrap seen in the last run
o_aborted  out  1  sticky: last run was aborted
o_words  out  CNT_W  words transferred in the current or last run
o_signature  out  WIDTH  running signature

Behaviour:
- Reset values: all outputs 0; state IDLE; captured seed, taps and count are 0.
- States are IDLE, LOAD, RUN and DONE.
- IDLE:
  - On i_start, capture seed, taps and count.
  - Clear o_words, o_signature, o_wrapped and o_aborted.
  - Go to LOAD.
- LOAD (exactly 1 cycle):
  - o_lfsr_enable=1 and o_lfsr_seed_load=1; o_valid=0.
  - Next state is RUN, except: DONE if count==0 or i_abort.
- RUN:
  - o_valid=1; o_data=i_lfsr_value; o_lfsr_seed_load=0.
  - o_lfsr_enable = i_ready, so the LFSR advances only on a handshake.
  - o_data holds stable while i_ready=0.
- On each handshake (o_valid & i_ready):
  - o_words increments.
  - o_signature <= {o_signature[WIDTH-2:0], o_signature[WIDTH-1]} ^ o_data.
- Word-count termination: the handshake that makes o_words==count moves the FSM to DONE. o_valid is low the following cycle.
- Wrap detection:
  - Condition: in RUN, i_lfsr_wrap=1 and o_words!=0. The first word, which is always the seed, never counts as a wrap.
  - Sets o_wrapped.
  - If STOP_ON_WRAP=1, go to DONE with no handshake that cycle; the repeated seed is not emitted.
- i_abort in RUN:
  - Go to DONE; set o_aborted.
  - A handshake in the same cycle still counts.
  - Abort has priority over both count and wrap termination.
- DONE (1 cycle): o_done=1, o_busy=0, o_valid=0; next state IDLE.
- Holding: i_start outside IDLE is ignored. o_words, o_signature, o_wrapped and o_aborted hold until the next start.
- Latency: a start in cycle T gives LOAD in T+1. The first o_valid is in T+2, with o_data equal to the seed.
- Reset mid-run returns to IDLE immediately, with all outputs at their reset values.

Test Plan:
- Zero count:
  - Stimulus: WIDTH=8, i_cfg_count=0, start.
  - Required: LOAD then DONE; o_done at T+2; no o_valid; o_words=0; o_signature=0x00.
- Two words, full throughput:
  - Stimulus: seed=0x01, count=2, consumer words 0x01,0x02 from the golden LFSR, ready held high.
  - Required: 2 handshakes at T+2 and T+3; o_signature=0x00 (0x01, then rot(0x01)^0x02=0x00); o_done at T+4.
- Backpressure:
  - Stimulus: count=3, i_ready low for 5 cycles after the first handshake.
  - Required: o_data and o_valid stable; o_lfsr_enable=0 throughout the stall; final words match the golden model; o_words=3.
- Wrap stop:
  - Stimulus: WIDTH=3, taps {3,2}, seed=3'b000, count=10, STOP_ON_WRAP=1.
  - Required: exactly 7 words; o_wrapped=1; o_words=7.
- Abort:
  - Stimulus: count=100, assert i_abort on the cycle of the 4th handshake.
  - Required: o_words=4; o_aborted=1; o_done the next cycle.
- Start while busy and async reset:
  - Stimulus: i_start during RUN; then i_rst_n low mid-RUN.
  - Required: the start is ignored; reset gives IDLE with all outputs 0 on the same edge.
